l2_queue_push_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single push port of the L2 request queue among NUM_REQ L1 requesters.

---
 rtl/l2_queue_push_arbiter_pkg.sv | 31 +++
 rtl/l2_queue_push_arbiter_if.sv | 35 +++
 rtl/l2_queue_push_arbiter_rr_arbiter.sv | 29 ++
 rtl/l2_queue_push_arbiter.sv | 142 ++++++++++++++
 tb/tb_l2_queue_push_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/l2_queue_push_arbiter_pkg.sv
// Shared definitions for the L2 request-queue push arbiter:
// op codes, FSM state encodings and the header field layout.
package l2_queue_push_arbiter_pkg;

   localparam int NUM_REQ_DEFAULT        = 4;
   localparam int REQ_ID_BITS_DEFAULT    = 2;
   localparam int REQUEST_SIZE_DEFAULT   = 38;
   localparam int ADDR_WIDTH_DEFAULT     = 32;
   localparam int DATA_WIDTH_DEFAULT     = 32;
   localparam int CYCLE_NUM_DATA_DEFAULT = 1;

   typedef logic [1:0] op_t;

   localparam op_t OP_RD      = 2'b00;
   localparam op_t OP_WR      = 2'b01;
   localparam op_t OP_PWB     = 2'b10;
   localparam op_t OP_ILLEGAL = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam int ID_LSB = 34;
   localparam int OP_LSB = 32;

   function automatic logic is_write_op(input op_t op);
      return (op == OP_WR) || (op == OP_PWB);
   endfunction

endpackage

// File: rtl/l2_queue_push_arbiter_if.sv
// Requester-side and queue-side signals of the push arbiter.
// master is the arbiter itself, slave is the requesters plus the queue.
interface l2_queue_push_arbiter_if
   import l2_queue_push_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = NUM_REQ_DEFAULT,
   parameter int REQ_ID_BITS  = REQ_ID_BITS_DEFAULT,
   parameter int REQUEST_SIZE = REQUEST_SIZE_DEFAULT,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT
) ();

   logic [NUM_REQ-1:0]            req_valid;
   logic [2*NUM_REQ-1:0]          req_op;
   logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ack;
   logic                          q_full;
   logic                          q_push_en;
   logic [1:0]                    q_op;
   logic [REQUEST_SIZE-1:0]       q_buf_in;
   logic                          busy;
   logic [REQ_ID_BITS-1:0]        grant_id;

   modport master (
      input  req_valid, req_op, req_addr, req_data, q_full,
      output req_ack, q_push_en, q_op, q_buf_in, busy, grant_id
   );

   modport slave (
      output req_valid, req_op, req_addr, req_data, q_full,
      input  req_ack, q_push_en, q_op, q_buf_in, busy, grant_id
   );

endinterface

// File: rtl/l2_queue_push_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Shared between the push and pop sides of the L2 request queue.
module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int IDX_BITS = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [IDX_BITS-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [IDX_BITS-1:0] grant_idx
);

   // Walk the slots from farthest to nearest so the nearest valid one is written last.
   always_comb begin
      int slot;
      grant     = '0;
      grant_idx = '0;
      slot      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         slot = (int'(ptr) + k) % NUM_REQ;
         if (req[slot]) begin
            grant       = '0;
            grant[slot] = 1'b1;
            grant_idx   = IDX_BITS'(slot);
         end
      end
   end

endmodule

// File: rtl/l2_queue_push_arbiter.sv
// Round-robin push arbiter for the L2 request queue: serialises each requester's
// transaction into a header beat, optional data beats and a turnaround cycle.
module l2_queue_push_arbiter
   import l2_queue_push_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = NUM_REQ_DEFAULT,
   parameter int REQ_ID_BITS    = REQ_ID_BITS_DEFAULT,
   parameter int REQUEST_SIZE   = REQUEST_SIZE_DEFAULT,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
   parameter int CYCLE_NUM_DATA = CYCLE_NUM_DATA_DEFAULT
) (
   input logic                     clk,
   input logic                     rst,
   l2_queue_push_arbiter_if.master bus
);

   logic [1:0]              state;
   logic [3:0]              beat_cnt;
   logic [REQ_ID_BITS-1:0]  rr_ptr;
   logic [REQ_ID_BITS-1:0]  lat_id;
   op_t                     lat_op;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_data;
   logic [NUM_REQ-1:0]      win_onehot;
   logic [REQ_ID_BITS-1:0]  win_idx;
   op_t                     win_op;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_data;
   logic [REQUEST_SIZE-1:0] hdr_beat;
   logic [REQUEST_SIZE-1:0] data_beat;
   logic [REQ_ID_BITS-1:0]  next_ptr;
   logic [NUM_REQ-1:0]      ack_vec;

   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .IDX_BITS (REQ_ID_BITS)
   ) u_rr_arbiter (
      .req       (bus.req_valid),
      .ptr       (rr_ptr),
      .grant     (win_onehot),
      .grant_idx (win_idx)
   );

   always_comb begin
      win_op   = OP_RD;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_onehot[i]) begin
            win_op   = bus.req_op[2*i +: 2];
            win_addr = bus.req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            win_data = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      hdr_beat                         = '0;
      hdr_beat[ADDR_WIDTH-1:0]         = lat_addr;
      hdr_beat[OP_LSB +: 2]            = lat_op;
      hdr_beat[ID_LSB +: REQ_ID_BITS]  = lat_id;
      data_beat                        = '0;
      data_beat[DATA_WIDTH-1:0]        = lat_data;
   end

   // Once a requester is served it drops to lowest priority.
   assign next_ptr = (int'(lat_id) == NUM_REQ - 1) ? '0 : lat_id + REQ_ID_BITS'(1);
   assign ack_vec  = NUM_REQ'(1) << lat_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         beat_cnt      <= '0;
         rr_ptr        <= '0;
         lat_id        <= '0;
         lat_op        <= OP_RD;
         lat_addr      <= '0;
         lat_data      <= '0;
         bus.req_ack   <= '0;
         bus.q_push_en <= 1'b0;
         bus.q_op      <= OP_RD;
         bus.q_buf_in  <= '0;
         bus.busy      <= 1'b0;
         bus.grant_id  <= '0;
      end else begin
         bus.req_ack   <= '0;
         bus.q_push_en <= 1'b0;
         bus.q_op      <= OP_RD;
         bus.q_buf_in  <= '0;
         case (state)
            ST_IDLE: begin
               if (|bus.req_valid && !bus.q_full) begin
                  lat_id       <= win_idx;
                  lat_op       <= win_op;
                  lat_addr     <= win_addr;
                  lat_data     <= win_data;
                  bus.grant_id <= win_idx;
                  bus.busy     <= 1'b1;
                  state        <= ST_HDR;
               end
            end
            ST_HDR: begin
               bus.q_op <= lat_op;
               if (lat_op != OP_ILLEGAL) begin
                  bus.q_push_en <= 1'b1;
                  bus.q_buf_in  <= hdr_beat;
               end
               if (is_write_op(lat_op)) begin
                  beat_cnt <= 4'(CYCLE_NUM_DATA);
                  state    <= ST_DATA;
               end else begin
                  bus.req_ack <= ack_vec;
                  rr_ptr      <= next_ptr;
                  bus.busy    <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            ST_DATA: begin
               bus.q_push_en <= 1'b1;
               bus.q_op      <= lat_op;
               bus.q_buf_in  <= data_beat;
               beat_cnt      <= beat_cnt - 4'd1;
               if (beat_cnt == 4'd1) begin
                  bus.req_ack <= ack_vec;
                  rr_ptr      <= next_ptr;
                  state       <= ST_GAP;
               end
            end
            ST_GAP: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_queue_push_arbiter.sv
// Self-checking bench for l2_queue_push_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level schedule model.
module tb_l2_queue_push_arbiter;
   import l2_queue_push_arbiter_pkg::*;

   localparam int NR  = 4;
   localparam int CND = 2;

   typedef struct packed {
      logic          push;
      logic [1:0]    op;
      logic [37:0]   buf_in;
      logic [NR-1:0] ack;
      logic          busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   l2_queue_push_arbiter_if #(
      .NUM_REQ(NR), .REQ_ID_BITS(2), .REQUEST_SIZE(38), .ADDR_WIDTH(32), .DATA_WIDTH(32)
   ) bus ();

   l2_queue_push_arbiter #(
      .NUM_REQ(NR), .REQ_ID_BITS(2), .REQUEST_SIZE(38), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .CYCLE_NUM_DATA(CND)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t          sched [int];
   int            gid_at [int];
   logic          pend [NR];
   logic [1:0]    p_op [NR];
   logic [31:0]   p_addr [NR];
   logic [31:0]   p_data [NR];
   logic [NR-1:0] drv_valid;
   int ptr, next_sample, inflight, cur_gid, cyc;
   int rate, full_rate, force_full;
   int checks, passes;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
   endtask

   function automatic exp_t getExp(input int c);
      exp_t e;
      e = '0;
      if (sched.exists(c)) e = sched[c];
      return e;
   endfunction

   task automatic resetModel();
      sched.delete();
      gid_at.delete();
      ptr = 0; next_sample = 0; inflight = -1; cur_gid = 0; cyc = 0;
      drv_valid = '0;
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
   endtask

   // Compare this cycle's outputs with the schedule, then let requesters see their acks.
   task automatic observe();
      exp_t e;
      e = getExp(cyc);
      if (gid_at.exists(cyc)) cur_gid = gid_at[cyc];
      checkOutput("q_push_en", 64'(bus.q_push_en), 64'(e.push));
      checkOutput("q_op",      64'(bus.q_op),      64'(e.op));
      checkOutput("q_buf_in",  64'(bus.q_buf_in),  64'(e.buf_in));
      checkOutput("req_ack",   64'(bus.req_ack),   64'(e.ack));
      checkOutput("busy",      64'(bus.busy),      64'(e.busy));
      checkOutput("grant_id",  64'(bus.grant_id),  64'(cur_gid));
      for (int i = 0; i < NR; i++) begin
         if (e.ack[i]) begin
            pend[i]  = 1'b0;
            ptr      = (i + 1) % NR;
            inflight = -1;
         end
      end
      if (sched.exists(cyc)) sched.delete(cyc);
      if (gid_at.exists(cyc)) gid_at.delete(cyc);
   endtask

   task automatic applyStimulus();
      logic drop;
      for (int i = 0; i < NR; i++) begin
         if (!pend[i] && rate > 0 && $urandom_range(0, 99) < rate) begin
            pend[i]   = 1'b1;
            p_op[i]   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            p_addr[i] = $urandom;
            p_data[i] = $urandom;
         end
         drop         = (i == inflight) && ($urandom_range(0, 3) == 0);
         drv_valid[i] = pend[i] && !drop;
         bus.req_valid[i]         = drv_valid[i];
         bus.req_op[2*i +: 2]     = drop ? 2'($urandom) : p_op[i];
         bus.req_addr[32*i +: 32] = drop ? $urandom : p_addr[i];
         bus.req_data[32*i +: 32] = drop ? $urandom : p_data[i];
      end
      if (force_full >= 0) bus.q_full = (force_full != 0);
      else bus.q_full = ($urandom_range(0, 99) < full_rate);
   endtask

   // Transaction-level model: on a grant, lay out every later cycle's expected outputs.
   task automatic scheduleModel();
      int   w, t;
      exp_t e;
      logic [37:0] hdr;
      w = -1;
      t = cyc;
      if (t < next_sample || bus.q_full || drv_valid == '0) return;
      for (int k = NR - 1; k >= 0; k--)
         if (drv_valid[(ptr + k) % NR]) w = (ptr + k) % NR;
      inflight    = w;
      gid_at[t+1] = w;
      e = getExp(t + 1); e.busy = 1'b1; sched[t+1] = e;
      hdr = 38'(p_addr[w]) + (38'(p_op[w]) << 32) + (38'(w) << 34);
      e = getExp(t + 2);
      e.op = p_op[w];
      if (p_op[w] != 2'b11) begin
         e.push   = 1'b1;
         e.buf_in = hdr;
      end
      if (p_op[w] == 2'b01 || p_op[w] == 2'b10) begin
         e.busy = 1'b1;
         sched[t+2] = e;
         for (int b = 1; b <= CND; b++) begin
            e = getExp(t + 2 + b);
            e.push   = 1'b1;
            e.op     = p_op[w];
            e.buf_in = 38'(p_data[w]);
            e.busy   = 1'b1;
            if (b == CND) e.ack = NR'(1) << w;
            sched[t+2+b] = e;
         end
         next_sample = t + 3 + CND;
      end else begin
         e.ack = NR'(1) << w;
         sched[t+2] = e;
         next_sample = t + 2;
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      observe();
      applyStimulus();
      scheduleModel();
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.req_valid = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_data = '0; bus.q_full = 1'b0;
      repeat (2) @(negedge clk);
      resetModel();
      rst = 1'b0;
      observe();
      applyStimulus();
      scheduleModel();
   endtask

   task automatic post(input int i, input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
      pend[i] = 1'b1; p_op[i] = op; p_addr[i] = addr; p_data[i] = data;
   endtask

   initial begin
      checks = 0; passes = 0;
      rate = 0; full_rate = 0; force_full = 0;
      for (int i = 0; i < NR; i++) begin
         p_op[i] = 2'b00; p_addr[i] = '0; p_data[i] = '0;
      end
      doReset();

      $display("[TB] single RD from requester 2");
      post(2, 2'b00, 32'h0000_1230, 32'h0);
      repeat (3) step();
      checkOutput("rd_header_value", 64'(bus.q_buf_in), 64'h8_0000_1230);
      checkOutput("rd_ack_value", 64'(bus.req_ack), 64'b0100);
      repeat (4) step();

      $display("[TB] WR from requester 1");
      doReset();
      post(1, 2'b01, 32'h0000_0040, 32'hDEAD_BEEF);
      repeat (4) step();
      checkOutput("wr_data_beat", 64'(bus.q_buf_in), 64'hDEAD_BEEF);
      checkOutput("wr_data_op", 64'(bus.q_op), 64'h1);
      repeat (6) step();

      $display("[TB] async reset during DATA");
      doReset();
      post(1, 2'b01, 32'h0000_0080, 32'h1234_5678);
      repeat (3) step();
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_push_en", 64'(bus.q_push_en), 64'h0);
      checkOutput("rst_buf_in", 64'(bus.q_buf_in), 64'h0);
      checkOutput("rst_busy", 64'(bus.busy), 64'h0);
      checkOutput("rst_grant_id", 64'(bus.grant_id), 64'h0);
      doReset();
      repeat (6) step();

      $display("[TB] four simultaneous RDs");
      doReset();
      for (int i = 0; i < NR; i++) post(i, 2'b00, 32'h100 * (i + 1), 32'h0);
      repeat (12) step();

      $display("[TB] queue full holds off a request");
      doReset();
      force_full = 1;
      post(0, 2'b00, 32'hABC0, 32'h0);
      repeat (5) step();
      force_full = 0;
      repeat (5) step();

      $display("[TB] PWB from 3 with RD from 0 arriving mid-transaction");
      doReset();
      post(3, 2'b10, 32'h0000_3000, 32'hCAFE_F00D);
      repeat (3) step();
      post(0, 2'b00, 32'h0000_0400, 32'h0);
      repeat (12) step();

      $display("[TB] random traffic");
      doReset();
      rate = 30; full_rate = 15; force_full = -1;
      repeat (800) step();
      rate = 0; force_full = 0;
      repeat (40) step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
